// File: rtl/if_fetch_buffer.sv
// -----------------------------------------------------------------------------
// if_fetch_buffer
//
// Instruction fetch buffer between the PC / instruction-ROM fetch stage and the
// ID stage. Each accepted fetch address is held for one cycle, then paired with
// the synchronous ROM word that returns for it. The pair is queued in a small
// FIFO, so an ID stall does not throw away fetches that are already issued.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   stall[5:0]  pipeline stall vector: [0] holds PC/fetch, [1] holds ID
//               (bits [5:2] belong to later stages and are ignored here)
//   flush       branch redirect: discard all queued and in-flight fetches
//   if_pc       fetch address presented to the instruction ROM this cycle
//   if_ce       ROM chip enable (1 = a fetch is being presented)
//   rom_inst    ROM read data for the address presented on the previous cycle
//   id_pc       address of the FIFO head (0 when empty)
//   id_inst     instruction word of the FIFO head (0 / NOP when empty)
//   id_valid    FIFO head is valid
//   fetch_full  to ctrl: no room for a further fetch, request stall[0]
//   ovf_err     sticky: a push was attempted while the FIFO was full
//
// Handshake: the ID side is valid/ready with id_valid as valid and ~stall[1]
// as ready; an entry leaves the FIFO only on a cycle where both are high
// (and no flush). The fetch side uses fetch_full as an inverted ready: ctrl is
// expected to raise stall[0] while fetch_full is high, and a fetch is taken
// only when if_ce is high and stall[0] and flush are both low.
// -----------------------------------------------------------------------------
module if_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic [AW-1:0] if_pc,
  input  logic          if_ce,
  input  logic [DW-1:0] rom_inst,
  output logic [AW-1:0] id_pc,
  output logic [DW-1:0] id_inst,
  output logic          id_valid,
  output logic          fetch_full,
  output logic          ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Entry storage; contents need no reset because the outputs are masked to
  // zero whenever the FIFO is empty.
  logic [AW-1:0] mem_pc   [DEPTH];
  logic [DW-1:0] mem_inst [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // Fetch issued last cycle whose ROM word arrives this cycle.
  logic          req_v;
  logic [AW-1:0] req_pc;

  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          ovf_now;
  logic [PW+1:0] occupancy;

  logic unused_stall;
  assign unused_stall = ^stall[5:2];

  assign full     = (count == DEPTH_C);
  assign id_valid = (count != '0);

  assign accept  = if_ce & ~stall[0] & ~flush;
  assign push    = req_v & ~flush;
  assign pop     = id_valid & ~stall[1] & ~flush;
  // A push into a full FIFO still fits if the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign ovf_now = push & full & ~pop;

  // Counts the in-flight fetch as occupied so ctrl can stall the PC from
  // registered state only; no pop term keeps ctrl free of a loop through ID.
  assign occupancy  = {1'b0, count} + {{(PW+1){1'b0}}, req_v};
  assign fetch_full = (occupancy >= {1'b0, DEPTH_C});

  assign id_pc   = id_valid ? mem_pc[rd_ptr]   : '0;
  assign id_inst = id_valid ? mem_inst[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_pc[wr_ptr]   <= req_pc;
      mem_inst[wr_ptr] <= rom_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_v  <= 1'b0;
      req_pc <= '0;
    end else begin
      req_v <= accept;
      if (accept) begin
        req_pc <= if_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (ovf_now) begin
        ovf_err <= 1'b1;
      end
      if (flush) begin
        // Empty the queue in place: the read pointer catches up to the write
        // pointer, which is left where it is.
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push_ok, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_buffer
//
// Directed plus short random stimulus for if_fetch_buffer. A reference model
// (expected queue, in-flight fetch register, sticky overflow flag) is stepped
// once per clock alongside the DUT. Inputs change on the falling edge and
// outputs are compared on the falling edge, before the next rising edge.
// The ROM is modelled as a synchronous lookup: rom_inst carries the word for
// the address presented at the previous rising edge.
// -----------------------------------------------------------------------------
module tb_if_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [5:0]    stall    = '0;
  logic          flush    = 1'b0;
  logic [AW-1:0] if_pc    = '0;
  logic          if_ce    = 1'b0;
  logic [DW-1:0] rom_inst = '0;
  logic [AW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic          id_valid;
  logic          fetch_full;
  logic          ovf_err;

  always #5 clk = ~clk;

  if_fetch_buffer #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .if_pc     (if_pc),
    .if_ce     (if_ce),
    .rom_inst  (rom_inst),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_valid  (id_valid),
    .fetch_full(fetch_full),
    .ovf_err   (ovf_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / model state
  // ---------------------------------------------------------------------------
  logic [AW+DW-1:0] exp_q[$];
  logic             m_req_v  = 1'b0;
  logic [AW-1:0]    m_req_pc = '0;
  logic             m_ovf    = 1'b0;
  int               n_cmp    = 0;
  int               n_err    = 0;
  bit               chk_on   = 1'b0;
  logic [AW-1:0]    pc_ctr   = 32'h0000_0800;

  // pc 0x0,0x4,0x8 -> 0x11,0x22,0x33; every address maps to a distinct word.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  function automatic logic m_full();
    return (exp_q.size() + int'(m_req_v)) >= DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the model, advance the model with the
  // inputs currently applied, then move to the next falling edge and drive
  // the ROM word for the address that was presented at the rising edge.
  task automatic cycle();
    logic [AW-1:0] edge_pc;
    logic          pp;
    if (chk_on) begin
      chk("id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
      chk("fetch_full", 64'(fetch_full), 64'(m_full()));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
      if (exp_q.size() != 0) chk("head", {id_pc, id_inst}, exp_q[0]);
      else                   chk("nop", {id_pc, id_inst}, 64'h0);
    end
    edge_pc = if_pc;
    if (rst) begin
      exp_q.delete();
      m_req_v  = 1'b0;
      m_req_pc = '0;
      m_ovf    = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_req_v = 1'b0;
    end else begin
      pp = (exp_q.size() != 0) && !stall[1];
      if (pp) void'(exp_q.pop_front());
      if (m_req_v) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({m_req_pc, rom_inst});
        else                      m_ovf = 1'b1;
      end
      m_req_v = if_ce & ~stall[0];
      if (m_req_v) m_req_pc = if_pc;
    end
    @(posedge clk);
    @(negedge clk);
    rom_inst = rom_word(edge_pc);
  endtask

  // Driver: honour=1 models a ctrl block that stalls the PC on fetch_full.
  task automatic step(input logic ce, input logic [AW-1:0] pc, input logic s1,
                      input logic fl, input logic honour);
    if_ce = ce;
    if_pc = pc;
    flush = fl;
    stall = {4'b0, s1, honour ? m_full() : 1'b0};
    cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset, then check the reset values while rst is still held.
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_on = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // Stream with no stalls: 0x0/0x4/0x8 -> 0x11/0x22/0x33 two cycles later.
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h4, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // ID stall for 6 cycles while fetching; fetch_full must rise, then drain.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h20 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Flush with 3 queued + 1 in flight, then branch target 0x100.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h40 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Prefill to two entries, then stream 12 fetches with push and pop
    // together so both pointers wrap several times.
    step(1'b1, 32'h300, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h304, 1'b1, 1'b0, 1'b1);
    for (int i = 2; i < 14; i++) step(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Forced overflow: fetch_full ignored while ID is held.
    for (int i = 0; i < 7; i++) step(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Reset with two entries queued (ovf_err is still set from above).
    step(1'b1, 32'h500, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h504, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Random traffic with a ctrl that honours fetch_full plus extra stalls.
    for (int i = 0; i < 80; i++) begin
      if_ce = 1'($urandom_range(0, 3) != 0);
      if_pc = pc_ctr;
      pc_ctr = pc_ctr + 32'd4;
      stall = {4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               m_full() | 1'($urandom_range(0, 3) == 0)};
      flush = 1'($urandom_range(0, 15) == 0);
      cycle();
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
